deser_1to4: RTL and testbench
=============================

# deser_1to4

Serial-to-parallel deserializer. It gathers a one-bit stream into 4-bit words and hands each word downstream over a valid/ready handshake. It is the fan-out counterpart of the team's 4-input OR reduction gates. Its 4-bit output word is the kind of bundle those gates reduce. It is used in lab datapaths to feed 4-wide gate and adder blocks from a single-bit test source.

## Interface
Parameters:
- MSB_FIRST, 0: 0 means the first accepted bit lands in out_word[0]. 1 means the first accepted bit lands in out_word[3].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block can accept in_bit this cycle. Combinational.
- out_word  output  4  assembled word. Registered.
- out_valid  output  1  out_word holds an unconsumed word. Registered.
- out_ready  input  1  downstream accepts out_word this cycle.
- any_set  output  1  registered OR of the four out_word bits. Present only with DESER_ANY_EN.

## Operation
- Handshake rules:
  - A bit is accepted on an edge where in_valid && in_ready.
  - A word is consumed on an edge where out_valid && out_ready.
- State machine: a 2-bit counter cnt acts as the state (S0..S3). cnt is the number of bits held in a 3-bit partial register part[2:0].
  - Sn to Sn+1 (n<3) on an accepted bit. The bit is stored in part[n].
  - S3 to S0 on an accepted bit. out_word loads {in_bit, part[2:0]} when MSB_FIRST=0, or the bit-reversed order when MSB_FIRST=1. out_valid is set to 1.
  - With no accepted bit, the state holds.
- Ready rule: in_ready = !(cnt==3 && out_valid && !out_ready).
  - Bits 1–3 of the next word are accepted while the previous word is still held.
  - Only completion of a word stalls.
- out_valid:
  - Set when a word completes.
  - Cleared on a consume edge with no completion.
  - Held at 1 on an edge that both consumes and completes. out_word takes the new word in that case.
- out_word and any_set change only on a completion edge.
- Reset (rst=1 on an edge) overrides all other activity:
  - cnt=0, part=0, out_word=4'b0000, out_valid=0, any_set=0.
  - in_ready reads 1 in the cycle after reset.
  - A partial word or an unconsumed held word is discarded.
- in_bit is a don't-care when in_valid=0. Nothing is accepted while rst=1.

## Timing
- Latency: if the 4th bit is accepted at edge k, out_valid and out_word are visible after edge k.
- Peak throughput: one word per 4 cycles with in_valid held high and out_ready held high. No bubbles.
- in_ready depends combinationally on out_ready only in state S3 with out_valid=1. No other combinational input-to-output paths exist.
- There is no gate delay on registers. Outputs update at the clock edge only.

## Configuration
- Macro DESER_ANY_EN.
  - Defined: port any_set exists. any_set is loaded with the OR of the four new word bits on each completion edge and reset to 0.
  - Undefined: the any_set port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: after rst=1 for 2 cycles, out_valid=0, out_word=0000, in_ready=1, any_set=0.
- Basic LSB-first word, MSB_FIRST=0: stream 1,0,1,1 with out_ready=1.
  - Required: out_valid=1 with out_word=4'b1101 after the 4th edge, then out_valid=0 one cycle later.
  - With DESER_ANY_EN, any_set=1.
- Backpressure: with out_ready=0, send 8 bits (word A 0,0,0,0 then word B 1,1,1,1).
  - Required: the first 3 bits of B are accepted. in_ready=0 at B's 4th bit. out_word stays 0000 and any_set stays 0.
  - Raise out_ready: A is consumed, B's 4th bit is accepted on the same edge, and out_word becomes 1111 with out_valid held at 1.
- Back-to-back: 12 consecutive valid bits with out_ready=1 produce exactly 3 words, one every 4 cycles, with in_ready constantly 1.
- MSB_FIRST=1: stream 1,0,0,0, which must yield out_word=4'b1000.
- Mid-operation reset: accept 2 bits, assert rst for one cycle, then send 0,1,1,0.
  - Required: a single word 4'b0110 (MSB_FIRST=0).
  - The pre-reset bits must not appear.

Source files
------------

// File: rtl/deser_1to4.sv
// deser_1to4: 1-bit serial stream to 4-bit words over valid/ready.
// Ports: clk, rst (sync, high), in_bit/in_valid/in_ready (serial side),
// out_word/out_valid/out_ready (word side), any_set (only with DESER_ANY_EN).
// MSB_FIRST=0 puts the first bit in out_word[0]; 1 puts it in out_word[3].
module deser_1to4 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_word,
  output logic       out_valid,
  input  logic       out_ready
`ifdef DESER_ANY_EN
  ,
  output logic       any_set
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t     cnt;
  logic [2:0] part;
  logic       accept;
  logic       consume;
  logic       done;
  logic [3:0] word;

  // Only the completing bit has to wait for the held word to drain.
  assign in_ready = !(cnt == S3 && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign done     = accept && (cnt == S3);

  always_comb begin
    word = {in_bit, part[2], part[1], part[0]};
    if (MSB_FIRST)
      word = {part[0], part[1], part[2], in_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= S0;
      part      <= 3'b000;
      out_word  <= 4'b0000;
      out_valid <= 1'b0;
`ifdef DESER_ANY_EN
      any_set   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        unique case (cnt)
          S0: begin
            part[0] <= in_bit;
            cnt     <= S1;
          end
          S1: begin
            part[1] <= in_bit;
            cnt     <= S2;
          end
          S2: begin
            part[2] <= in_bit;
            cnt     <= S3;
          end
          S3: begin
            out_word <= word;
`ifdef DESER_ANY_EN
            any_set  <= |word;
`endif
            cnt      <= S0;
          end
        endcase
      end
      // Completion wins over consume so a word handed over
      // and replaced on the same edge stays valid.
      if (done)
        out_valid <= 1'b1;
      else if (consume)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser_1to4.sv
// tb_deser_1to4: directed table-driven bench for deser_1to4.
// Second instance with MSB_FIRST=1 shares the input stream.
module tb_deser_1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic       m_in_ready;
  logic [3:0] m_out_word;
  logic       m_out_valid;
`ifdef DESER_ANY_EN
  logic       any_set;
  logic       m_any_set;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  deser_1to4 #(.MSB_FIRST(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DESER_ANY_EN
    ,
    .any_set   (any_set)
`endif
  );

  deser_1to4 #(.MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (m_in_ready),
    .out_word  (m_out_word),
    .out_valid (m_out_valid),
    .out_ready (out_ready)
`ifdef DESER_ANY_EN
    ,
    .any_set   (m_any_set)
`endif
  );

  typedef struct {
    logic       r;
    logic       b;
    logic       v;
    logic       o;
    logic       ir;
    logic       ov;
    logic [3:0] ow;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Drive inputs just after an edge, let them settle.
  task automatic drive(input logic r, input logic b,
                       input logic v, input logic o);
    rst       = r;
    in_bit    = b;
    in_valid  = v;
    out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic b, input logic v,
                     input logic o, input logic ir, input logic ov,
                     input logic [3:0] ow);
    vec_t e;
    e.r = r; e.b = b; e.v = v; e.o = o;
    e.ir = ir; e.ov = ov; e.ow = ow;
    tbl.push_back(e);
  endtask

  initial begin
    // basic LSB-first 1,0,1,1
    add(0, 1, 1, 1, 1, 0, 4'b0000);
    add(0, 0, 1, 1, 1, 0, 4'b0000);
    add(0, 1, 1, 1, 1, 0, 4'b0000);
    add(0, 1, 1, 1, 1, 1, 4'b1101);
    add(0, 0, 0, 1, 1, 0, 4'b1101);
    // backpressure: A=0000 then B=1111, out_ready low
    add(0, 0, 1, 0, 1, 0, 4'b1101);
    add(0, 0, 1, 0, 1, 0, 4'b1101);
    add(0, 0, 1, 0, 1, 0, 4'b1101);
    add(0, 0, 1, 0, 1, 1, 4'b0000);
    add(0, 1, 1, 0, 1, 1, 4'b0000);
    add(0, 1, 1, 0, 1, 1, 4'b0000);
    add(0, 1, 1, 0, 1, 1, 4'b0000);
    add(0, 1, 1, 0, 0, 1, 4'b0000);
    add(0, 1, 1, 0, 0, 1, 4'b0000);
    add(0, 1, 1, 1, 1, 1, 4'b1111);
    add(0, 0, 0, 1, 1, 0, 4'b1111);
    // back-to-back: 0100 1100 0001
    add(0, 0, 1, 1, 1, 0, 4'b1111);
    add(0, 1, 1, 1, 1, 0, 4'b1111);
    add(0, 0, 1, 1, 1, 0, 4'b1111);
    add(0, 0, 1, 1, 1, 1, 4'b0010);
    add(0, 1, 1, 1, 1, 0, 4'b0010);
    add(0, 1, 1, 1, 1, 0, 4'b0010);
    add(0, 0, 1, 1, 1, 0, 4'b0010);
    add(0, 0, 1, 1, 1, 1, 4'b0011);
    add(0, 0, 1, 1, 1, 0, 4'b0011);
    add(0, 0, 1, 1, 1, 0, 4'b0011);
    add(0, 0, 1, 1, 1, 0, 4'b0011);
    add(0, 1, 1, 1, 1, 1, 4'b1000);
    add(0, 0, 0, 1, 1, 0, 4'b1000);
    // mid-op reset after 2 bits, then 0,1,1,0
    add(0, 1, 1, 1, 1, 0, 4'b1000);
    add(0, 1, 1, 1, 1, 0, 4'b1000);
    add(1, 1, 1, 1, 1, 0, 4'b0000);
    add(0, 0, 1, 1, 1, 0, 4'b0000);
    add(0, 1, 1, 1, 1, 0, 4'b0000);
    add(0, 1, 1, 1, 1, 0, 4'b0000);
    add(0, 0, 1, 1, 1, 1, 4'b0110);
    add(0, 0, 0, 1, 1, 0, 4'b0110);

    // reset for 2 cycles
    drive(1, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0);
    chk("rst_out_valid", {3'b0, out_valid}, 4'b0000);
    chk("rst_out_word", out_word, 4'b0000);
    chk("rst_in_ready", {3'b0, in_ready}, 4'b0001);
`ifdef DESER_ANY_EN
    chk("rst_any_set", {3'b0, any_set}, 4'b0000);
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].b, tbl[i].v, tbl[i].o);
      chk($sformatf("v%0d_in_ready", i), {3'b0, in_ready},
          {3'b0, tbl[i].ir});
      tick();
      chk($sformatf("v%0d_out_valid", i), {3'b0, out_valid},
          {3'b0, tbl[i].ov});
      chk($sformatf("v%0d_out_word", i), out_word, tbl[i].ow);
`ifdef DESER_ANY_EN
      chk($sformatf("v%0d_any_set", i), {3'b0, any_set},
          {3'b0, |tbl[i].ow});
`endif
    end

    // reset discards a held, unconsumed word
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0);
      tick();
    end
    chk("hold_valid", {3'b0, out_valid}, 4'b0001);
    chk("hold_word", out_word, 4'b1111);
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    chk("hrst_valid", {3'b0, out_valid}, 4'b0000);
    chk("hrst_word", out_word, 4'b0000);
    chk("hrst_in_ready", {3'b0, in_ready}, 4'b0001);

    // MSB_FIRST: stream 1,0,0,0 into both instances
    drive(0, 1, 1, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    chk("msb_valid", {3'b0, m_out_valid}, 4'b0001);
    chk("msb_word", m_out_word, 4'b1000);
    chk("lsb_word", out_word, 4'b0001);
`ifdef DESER_ANY_EN
    chk("msb_any_set", {3'b0, m_any_set}, 4'b0001);
`endif
    tick();
    chk("msb_consumed", {3'b0, m_out_valid}, 4'b0000);
    chk("msb_word_kept", m_out_word, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
